mmc_spi_cmd_responder: RTL and testbench

Card-side responder for the SPI-mode MMC command protocol. It consumes the byte stream the host-side command control layers emit (6-byte command frame), decodes it, and returns an R1 response after a programmable N_CR gap, modelling idle/initialization state across CMD0/CMD1/CMD16. It sits behind an SPI slave byte PHY and is used as the emulated card in bring-up and loopback benches of the MMC controller.

---
 rtl/mmc_pkg.sv | 34 +++
 rtl/mmc_spi_r1_gen.sv | 61 ++++++
 rtl/mmc_spi_cmd_responder.sv | 152 +++++++++++++++
 tb/tb_mmc_spi_cmd_responder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mmc_pkg.sv
// Shared definitions for the SPI-mode MMC command responder: FSM states,
// R1 response bits, command indices and framing constants.
package mmc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARG,
    ST_CRC,
    ST_NCR,
    ST_RESP
  } mmc_state_t;

  localparam logic [7:0] R1_IDLE      = 8'h01;
  localparam logic [7:0] R1_ILLEGAL   = 8'h04;
  localparam logic [7:0] R1_CRC_ERR   = 8'h08;
  localparam logic [7:0] R1_PARAM_ERR = 8'h40;
  localparam logic [7:0] R1_READY     = 8'h00;

  localparam logic [5:0] CMD0  = 6'd0;
  localparam logic [5:0] CMD1  = 6'd1;
  localparam logic [5:0] CMD16 = 6'd16;

  localparam logic [7:0]  CMD0_CRC    = 8'h95;
  localparam logic [7:0]  START_MASK  = 8'hC0;
  localparam logic [7:0]  START_VALUE = 8'h40;
  localparam logic [7:0]  FILL_BYTE   = 8'hFF;
  localparam logic [31:0] BLOCK_512   = 32'd512;

  // A frame starts with '01' in the two top bits; the rest is the index.
  function automatic logic is_start_byte(input logic [7:0] value);
    return (value & START_MASK) == START_VALUE;
  endfunction

endpackage

// File: rtl/mmc_spi_r1_gen.sv
// Combinational command evaluator: given a decoded frame and the card's
// idle/initialization state, produces the R1 byte and the next state values.
module mmc_spi_r1_gen
  import mmc_pkg::*;
#(
  parameter int P_INIT_POLLS = 2
) (
  input  logic [5:0]  index,
  input  logic [31:0] arg,
  input  logic [7:0]  crc,
  input  logic        idle,
  input  logic [3:0]  counter,
  output logic [7:0]  r1,
  output logic        idle_next,
  output logic [3:0]  counter_next
);

  localparam logic [3:0] INIT_POLLS = 4'(P_INIT_POLLS);

  // Decode the command; only CMD0 has its CRC checked, everything else is trusted.
  always_comb begin
    r1           = R1_ILLEGAL | {7'b0, idle};
    idle_next    = idle;
    counter_next = counter;
    case (index)
      CMD0: begin
        if (crc == CMD0_CRC) begin
          idle_next    = 1'b1;
          counter_next = INIT_POLLS;
          r1           = R1_IDLE;
        end else begin
          r1 = R1_CRC_ERR | {7'b0, idle};
        end
      end
      CMD1: begin
        if (idle && counter != 4'd0) begin
          counter_next = counter - 4'd1;
          r1           = R1_IDLE;
        end else if (idle) begin
          idle_next = 1'b0;
          r1        = R1_READY;
        end else begin
          r1 = R1_READY;
        end
      end
      CMD16: begin
        if (idle) begin
          r1 = R1_IDLE;
        end else if (arg == BLOCK_512) begin
          r1 = R1_READY;
        end else begin
          r1 = R1_PARAM_ERR;
        end
      end
      default: begin
        r1 = R1_ILLEGAL | {7'b0, idle};
      end
    endcase
  end

endmodule

// File: rtl/mmc_spi_cmd_responder.sv
// Card-side SPI-mode MMC command responder: frames the 6-byte command,
// hands it to the R1 evaluator and plays the response back after the N_CR gap.
module mmc_spi_cmd_responder
  import mmc_pkg::*;
#(
  parameter int P_NCR        = 1,
  parameter int P_INIT_POLLS = 2
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iRESET_SYNC,
  input  logic        iMMC_CS,
  input  logic        iMMC_VALID,
  input  logic [7:0]  iMMC_DATA,
  output logic [7:0]  oMMC_DATA,
  output logic        oCMD_VALID,
  output logic [5:0]  oCMD_INDEX,
  output logic [31:0] oCMD_ARG,
  output logic        oIDLE
);

  localparam logic [3:0] NCR_TARGET = 4'(P_NCR);
  localparam logic [3:0] INIT_POLLS = 4'(P_INIT_POLLS);

  mmc_state_t  state, state_next;
  logic [5:0]  frame_index, frame_index_next;
  logic [31:0] arg_shift, arg_shift_next;
  logic [1:0]  byte_count, byte_count_next;
  logic [3:0]  gap_count, gap_count_next;
  logic [7:0]  r1_reg, r1_reg_next;
  logic        idle_flag, idle_flag_next;
  logic [3:0]  init_count, init_count_next;
  logic [7:0]  data_next;
  logic        cmd_valid_next;
  logic [5:0]  cmd_index_next;
  logic [31:0] cmd_arg_next;

  logic [7:0]  gen_r1;
  logic        gen_idle;
  logic [3:0]  gen_count;

  // The CRC byte is evaluated straight off the bus in the cycle it arrives.
  mmc_spi_r1_gen #(
    .P_INIT_POLLS(P_INIT_POLLS)
  ) u_r1_gen (
    .index       (frame_index),
    .arg         (arg_shift),
    .crc         (iMMC_DATA),
    .idle        (idle_flag),
    .counter     (init_count),
    .r1          (gen_r1),
    .idle_next   (gen_idle),
    .counter_next(gen_count)
  );

  // Register every piece of state; either reset source forces the power-up values.
  always_ff @(posedge iCLOCK) begin
    if (!inRESET || iRESET_SYNC) begin
      state       <= ST_IDLE;
      frame_index <= 6'd0;
      arg_shift   <= 32'd0;
      byte_count  <= 2'd0;
      gap_count   <= 4'd0;
      r1_reg      <= FILL_BYTE;
      idle_flag   <= 1'b1;
      init_count  <= INIT_POLLS;
      oMMC_DATA   <= FILL_BYTE;
      oCMD_VALID  <= 1'b0;
      oCMD_INDEX  <= 6'd0;
      oCMD_ARG    <= 32'd0;
    end else begin
      state       <= state_next;
      frame_index <= frame_index_next;
      arg_shift   <= arg_shift_next;
      byte_count  <= byte_count_next;
      gap_count   <= gap_count_next;
      r1_reg      <= r1_reg_next;
      idle_flag   <= idle_flag_next;
      init_count  <= init_count_next;
      oMMC_DATA   <= data_next;
      oCMD_VALID  <= cmd_valid_next;
      oCMD_INDEX  <= cmd_index_next;
      oCMD_ARG    <= cmd_arg_next;
    end
  end

  // Framing FSM: chip-select deassertion aborts anything in flight, else advance per received byte.
  always_comb begin
    state_next       = state;
    frame_index_next = frame_index;
    arg_shift_next   = arg_shift;
    byte_count_next  = byte_count;
    gap_count_next   = gap_count;
    r1_reg_next      = r1_reg;
    idle_flag_next   = idle_flag;
    init_count_next  = init_count;
    data_next        = oMMC_DATA;
    cmd_valid_next   = 1'b0;
    cmd_index_next   = oCMD_INDEX;
    cmd_arg_next     = oCMD_ARG;

    if (iMMC_CS) begin
      state_next = ST_IDLE;
      data_next  = FILL_BYTE;
    end else if (iMMC_VALID) begin
      case (state)
        ST_IDLE: begin
          if (is_start_byte(iMMC_DATA)) begin
            frame_index_next = iMMC_DATA[5:0];
            byte_count_next  = 2'd0;
            state_next       = ST_ARG;
          end
        end
        ST_ARG: begin
          arg_shift_next  = {arg_shift[23:0], iMMC_DATA};
          byte_count_next = byte_count + 2'd1;
          if (byte_count == 2'd3) begin
            state_next = ST_CRC;
          end
        end
        ST_CRC: begin
          cmd_valid_next  = 1'b1;
          cmd_index_next  = frame_index;
          cmd_arg_next    = arg_shift;
          r1_reg_next     = gen_r1;
          idle_flag_next  = gen_idle;
          init_count_next = gen_count;
          gap_count_next  = 4'd0;
          state_next      = ST_NCR;
        end
        ST_NCR: begin
          gap_count_next = gap_count + 4'd1;
          if (gap_count + 4'd1 == NCR_TARGET) begin
            data_next  = r1_reg;
            state_next = ST_RESP;
          end
        end
        ST_RESP: begin
          data_next  = FILL_BYTE;
          state_next = ST_IDLE;
        end
        default: begin
          state_next = ST_IDLE;
          data_next  = FILL_BYTE;
        end
      endcase
    end
  end

  assign oIDLE = idle_flag;

endmodule

// File: tb/tb_mmc_spi_cmd_responder.sv
// Self-checking bench for mmc_spi_cmd_responder: two instances (N_CR of 1 and 4),
// a table of command frames plus hand-written abort and reset sequences.
module tb_mmc_spi_cmd_responder;

  logic        clock = 1'b0;
  logic        resetN;
  logic        resetSync;
  logic        cs[2];
  logic        valid[2];
  logic [7:0]  mosi[2];
  logic [7:0]  miso[2];
  logic        cmdValid[2];
  logic [5:0]  cmdIndex[2];
  logic [31:0] cmdArg[2];
  logic        idleFlag[2];

  int testsRun    = 0;
  int testsFailed = 0;
  int pulseCount4 = 0;
  logic [7:0] expQ[$];

  typedef struct {
    logic [47:0] frame;
    logic [7:0]  r1;
    logic        idle;
  } vec_t;

  vec_t vecs[13];

  // Free-running 100 MHz clock.
  always #5 clock = ~clock;

  mmc_spi_cmd_responder #(.P_NCR(1), .P_INIT_POLLS(2)) dut1 (
    .iCLOCK     (clock),
    .inRESET    (resetN),
    .iRESET_SYNC(resetSync),
    .iMMC_CS    (cs[0]),
    .iMMC_VALID (valid[0]),
    .iMMC_DATA  (mosi[0]),
    .oMMC_DATA  (miso[0]),
    .oCMD_VALID (cmdValid[0]),
    .oCMD_INDEX (cmdIndex[0]),
    .oCMD_ARG   (cmdArg[0]),
    .oIDLE      (idleFlag[0])
  );

  mmc_spi_cmd_responder #(.P_NCR(4), .P_INIT_POLLS(2)) dut4 (
    .iCLOCK     (clock),
    .inRESET    (resetN),
    .iRESET_SYNC(resetSync),
    .iMMC_CS    (cs[1]),
    .iMMC_VALID (valid[1]),
    .iMMC_DATA  (mosi[1]),
    .oMMC_DATA  (miso[1]),
    .oCMD_VALID (cmdValid[1]),
    .oCMD_INDEX (cmdIndex[1]),
    .oCMD_ARG   (cmdArg[1]),
    .oIDLE      (idleFlag[1])
  );

  // Count decoded-frame pulses of the N_CR=4 instance to catch aborted frames slipping through.
  always @(posedge clock) begin
    if (cmdValid[1] === 1'b1) pulseCount4++;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One byte exchange: host reads what the card presents, then clocks its own byte in.
  task automatic applyStimulus(input int sel, input logic [7:0] b);
    logic [7:0] seen;
    logic [7:0] want;
    @(negedge clock);
    seen = miso[sel];
    if (expQ.size() == 0) begin
      checkOutput("scoreboard underflow", 32'(seen), 32'h1FF);
    end else begin
      want = expQ.pop_front();
      checkOutput("response byte", 32'(seen), 32'(want));
    end
    mosi[sel]  = b;
    valid[sel] = 1'b1;
    @(posedge clock);
    #1;
    valid[sel] = 1'b0;
  endtask

  // Full command frame followed by the N_CR gap and the R1 exchange.
  task automatic runFrame(input int sel, input logic [47:0] frame, input int ncr,
                          input logic [7:0] r1, input logic expIdle);
    for (int i = 0; i < 6 + ncr; i++) expQ.push_back(8'hFF);
    expQ.push_back(r1);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(sel, frame[47 - 8*i -: 8]);
    end
    checkOutput("cmd valid pulse", 32'(cmdValid[sel]), 32'h1);
    checkOutput("cmd index", 32'(cmdIndex[sel]), 32'(frame[45:40]));
    checkOutput("cmd arg", cmdArg[sel], frame[39:8]);
    for (int j = 0; j <= ncr; j++) begin
      applyStimulus(sel, 8'hFF);
      if (j == 0) checkOutput("cmd valid single cycle", 32'(cmdValid[sel]), 32'h0);
    end
    checkOutput("idle flag", 32'(idleFlag[sel]), 32'(expIdle));
  endtask

  task automatic checkResetState(input int sel);
    checkOutput("reset data", 32'(miso[sel]), 32'hFF);
    checkOutput("reset cmd valid", 32'(cmdValid[sel]), 32'h0);
    checkOutput("reset index", 32'(cmdIndex[sel]), 32'h0);
    checkOutput("reset arg", cmdArg[sel], 32'h0);
    checkOutput("reset idle", 32'(idleFlag[sel]), 32'h1);
  endtask

  initial begin
    vecs[0]  = '{48'h40_00000000_95, 8'h01, 1'b1};
    vecs[1]  = '{48'h40_00000000_00, 8'h09, 1'b1};
    vecs[2]  = '{48'h41_00000000_FF, 8'h01, 1'b1};
    vecs[3]  = '{48'h41_00000000_FF, 8'h01, 1'b1};
    vecs[4]  = '{48'h41_00000000_FF, 8'h00, 1'b0};
    vecs[5]  = '{48'h50_00000200_FF, 8'h00, 1'b0};
    vecs[6]  = '{48'h50_00000400_FF, 8'h40, 1'b0};
    vecs[7]  = '{48'h77_00000000_FF, 8'h04, 1'b0};
    vecs[8]  = '{48'h41_00000000_FF, 8'h00, 1'b0};
    vecs[9]  = '{48'h40_00000000_95, 8'h01, 1'b1};
    vecs[10] = '{48'h50_00000400_FF, 8'h01, 1'b1};
    vecs[11] = '{48'h77_12345678_FF, 8'h05, 1'b1};
    vecs[12] = '{48'h41_00000000_FF, 8'h01, 1'b1};

    resetN    = 1'b0;
    resetSync = 1'b0;
    for (int s = 0; s < 2; s++) begin
      cs[s]    = 1'b0;
      valid[s] = 1'b0;
      mosi[s]  = 8'hFF;
    end
    repeat (3) @(posedge clock);
    #1;
    checkResetState(0);
    checkResetState(1);
    resetN = 1'b1;

    // Table of frames on the N_CR=1 card, back to back.
    for (int v = 0; v < 13; v++) begin
      runFrame(0, vecs[v].frame, 1, vecs[v].r1, vecs[v].idle);
    end

    // Abort a CMD0 after three bytes; a start byte sent with CS high must be dropped.
    for (int i = 0; i < 3; i++) expQ.push_back(8'hFF);
    applyStimulus(1, 8'h40);
    applyStimulus(1, 8'h00);
    applyStimulus(1, 8'h00);
    @(negedge clock);
    cs[1]    = 1'b1;
    mosi[1]  = 8'h41;
    valid[1] = 1'b1;
    @(posedge clock);
    #1;
    valid[1] = 1'b0;
    checkOutput("cs abort data", 32'(miso[1]), 32'hFF);
    checkOutput("cs abort no pulse", 32'(cmdValid[1]), 32'h0);
    @(negedge clock);
    cs[1] = 1'b0;
    runFrame(1, 48'h41_00000000_FF, 4, 8'h01, 1'b1);
    checkOutput("pulses after abort", 32'(pulseCount4), 32'h1);
    runFrame(1, 48'h41_00000000_FF, 4, 8'h01, 1'b1);
    runFrame(1, 48'h41_00000000_FF, 4, 8'h00, 1'b0);

    // Reset low in the middle of the N_CR gap of a CMD16.
    for (int i = 0; i < 8; i++) expQ.push_back(8'hFF);
    for (int i = 0; i < 6; i++) applyStimulus(1, 8'(48'h50_00000200_FF >> (40 - 8*i)));
    applyStimulus(1, 8'hFF);
    applyStimulus(1, 8'hFF);
    checkOutput("pre-reset index", 32'(cmdIndex[1]), 32'd16);
    @(negedge clock);
    resetN = 1'b0;
    @(posedge clock);
    #1;
    resetN = 1'b1;
    checkResetState(1);
    runFrame(1, 48'h40_00000000_95, 4, 8'h01, 1'b1);

    // Soft reset while R1 is being presented.
    for (int i = 0; i < 10; i++) expQ.push_back(8'hFF);
    for (int i = 0; i < 6; i++) applyStimulus(1, 8'(48'h41_00000000_FF >> (40 - 8*i)));
    for (int i = 0; i < 4; i++) applyStimulus(1, 8'hFF);
    @(negedge clock);
    checkOutput("r1 presented", 32'(miso[1]), 32'h01);
    resetSync = 1'b1;
    @(posedge clock);
    #1;
    resetSync = 1'b0;
    checkResetState(1);
    runFrame(1, 48'h41_00000000_FF, 4, 8'h01, 1'b1);

    checkOutput("scoreboard drained", 32'(expQ.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
